// File: rtl/vga_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing the vga_adapter pixel-write port.
// Ports: clk/reset, per-engine req/last/req_x/req_y/req_color in; grant, vga_x/y/color/write, busy, owner, abort out.
module vga_write_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int COLOR_DEPTH = 9,
  parameter int MAX_BURST   = 1024
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             last,
  input  logic [NUM_REQ*nX-1:0]          req_x,
  input  logic [NUM_REQ*nY-1:0]          req_y,
  input  logic [NUM_REQ*COLOR_DEPTH-1:0] req_color,
  output logic [NUM_REQ-1:0]             grant,
  output logic [nX-1:0]                  vga_x,
  output logic [nY-1:0]                  vga_y,
  output logic [COLOR_DEPTH-1:0]         vga_color,
  output logic                           vga_write,
  output logic                           busy,
  output logic [2:0]                     owner,
  output logic                           abort
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                   state, state_n;
  logic [2:0]               ptr, ptr_n;
  logic [CW-1:0]            cnt, cnt_n;
  logic [CW-1:0]            cnt_inc;
  logic [NUM_REQ-1:0]       grant_n;
  logic [2:0]               owner_n;
  logic                     busy_n, abort_n, write_n;
  logic [nX-1:0]            x_n;
  logic [nY-1:0]            y_n;
  logic [COLOR_DEPTH-1:0]   color_n;

  logic                     found;
  logic [2:0]               pick;
  logic                     own_req, own_last, own_grant;
  logic [nX-1:0]            own_x;
  logic [nY-1:0]            own_y;
  logic [COLOR_DEPTH-1:0]   own_color;
  logic                     beat, done;

  // Rotating search from ptr+1; first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = 3'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[i] &&
            ((int'(ptr) + k) % NUM_REQ) == i) begin
          found = 1'b1;
          pick  = 3'(i);
        end
      end
    end
  end

  // Owner's lane of the flattened request bus.
  always_comb begin
    own_req   = 1'b0;
    own_last  = 1'b0;
    own_grant = 1'b0;
    own_x     = '0;
    own_y     = '0;
    own_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 3'(i)) begin
        own_req   = req[i];
        own_last  = last[i];
        own_grant = grant[i];
        own_x     = req_x[i*nX +: nX];
        own_y     = req_y[i*nY +: nY];
        own_color = req_color[i*COLOR_DEPTH +: COLOR_DEPTH];
      end
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    grant_n = grant;
    owner_n = owner;
    busy_n  = busy;
    abort_n = 1'b0;
    write_n = 1'b0;
    x_n     = vga_x;
    y_n     = vga_y;
    color_n = vga_color;
    beat    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        grant_n = '0;
        busy_n  = 1'b0;
        if (found) begin
          state_n = BURST;
          owner_n = pick;
          busy_n  = 1'b1;
          cnt_n   = '0;
          for (int i = 0; i < NUM_REQ; i++)
            grant_n[i] = (pick == 3'(i));
        end
      end
      BURST: begin
        beat = own_grant & own_req;
        if (beat) begin
          write_n = 1'b1;
          x_n     = own_x;
          y_n     = own_y;
          color_n = own_color;
          cnt_n   = cnt_inc;
          if (own_last) begin
            done = 1'b1;
          end else if (cnt_inc == CW'(MAX_BURST)) begin
            done    = 1'b1;
            abort_n = 1'b1;
          end
        end else begin
          // Owner dropped req mid-sprite.
          done    = 1'b1;
          abort_n = 1'b1;
        end
        if (done) begin
          state_n = IDLE;
          grant_n = '0;
          busy_n  = 1'b0;
          ptr_n   = owner;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= 3'(NUM_REQ - 1);
      cnt       <= '0;
      grant     <= '0;
      owner     <= 3'd0;
      busy      <= 1'b0;
      abort     <= 1'b0;
      vga_write <= 1'b0;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      grant     <= grant_n;
      owner     <= owner_n;
      busy      <= busy_n;
      abort     <= abort_n;
      vga_write <= write_n;
      vga_x     <= x_n;
      vga_y     <= y_n;
      vga_color <= color_n;
    end
  end

endmodule

// File: doc/vga_write_arbiter.md
Name: vga_write_arbiter

Overview:
- Shares the single pixel-write port of vga_adapter among NUM_REQ drawing engines (player, obstacle bank, score/HUD overlay).
- Replaces the fixed-priority combinational write mux with round-robin, burst-locked arbitration, so an engine erasing or redrawing a sprite is never interleaved with another engine mid-sprite.
- Registers the winning pixel stream onto the vga_adapter x/y/color/write inputs.

Parameters:
NUM_REQ, 3, number of requesting drawing engines (2..8)
nX, 10, x coordinate width
nY, 9, y coordinate width
COLOR_DEPTH, 9, pixel colour width
MAX_BURST, 1024, maximum beats per grant before forced release (power of two not required, >=2)

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
req  in  NUM_REQ  per-engine request; held high while engine has pixels to write
last  in  NUM_REQ  per-engine end-of-sprite marker, qualified by a beat
req_x  in  NUM_REQ*nX  flattened x, engine i at bits [i*nX +: nX]
req_y  in  NUM_REQ*nY  flattened y, same packing
req_color  in  NUM_REQ*COLOR_DEPTH  flattened colour, same packing
grant  out  NUM_REQ  one-hot grant, registered
vga_x  out  nX  registered pixel x to vga_adapter
vga_y  out  nY  registered pixel y
vga_color  out  COLOR_DEPTH  registered pixel colour
vga_write  out  1  registered write strobe
busy  out  1  high while state is BURST
owner  out  3  index of current/last grant holder
abort  out  1  one-cycle pulse when a burst ends without last (req drop or timeout)

Behaviour:
- Reset (synchronous, active-high, on clk): state=IDLE, grant=0, vga_x/vga_y/vga_color=0, vga_write=0, busy=0, owner=0, abort=0, rr pointer=NUM_REQ-1 (engine 0 wins first), beat counter=0. Reset mid-burst drops grant and vga_write on the next edge; no pixel is emitted for that cycle.
- States: IDLE, BURST.
- IDLE: if any req high, choose the first requester with req high, searching upward from ptr+1 with modulo wrap. Set grant one-hot, owner=index, busy=1, go to BURST. Grant is visible one cycle after req is sampled. If no req, stay in IDLE with grant=0.
- BURST: a beat is any cycle with grant[owner] & req[owner].
  - Each beat registers req_x/req_y/req_color of owner onto vga_x/vga_y/vga_color, with vga_write=1 on the next cycle (latency 1).
  - Non-beat cycles give vga_write=0; vga_x/vga_y/vga_color hold their values.
  - Beat counter increments on each beat.
- Burst termination, evaluated every BURST cycle, next edge returns to IDLE with grant=0, busy=0, ptr=owner, counter=0:
  - a) Beat with last[owner]=1: normal end, abort=0.
  - b) req[owner]=0 while granted: abort pulse; no pixel written that cycle.
  - c) Beat that makes the counter equal MAX_BURST without last: that pixel is written, then abort pulses.
- Minimum one IDLE cycle between bursts, so there is no back-to-back grant to the same or another engine. A sole requester still re-wins after that gap.
- Requests from non-owners during BURST are ignored (lock). They are served in round-robin order afterwards.
- last from a non-granted engine, or last without req, is ignored.
- owner holds its value in IDLE until the next grant.
- Inputs are sampled only on clk edges. Engines must hold x/y/color stable while req is high and grant is low.

Test Plan:
- Single burst: req[0]=1 with 4 beats (x=10..13, y=20, color=9'h1C0), last on beat 4 -> grant=3'b001 one cycle after req; vga_write high for exactly 4 cycles, each 1 cycle after its beat, carrying x=10..13; busy then drops; abort never pulses.
- Round-robin: req[0], req[1], req[2] all rise together, each sending 2-beat bursts -> grant order 0,1,2,0,… with exactly one idle cycle between grants; vga_write never carries two engines' pixels in one burst window.
- Lock: req[1] rises during the 2nd beat of engine 0's 5-beat burst -> grant[1] stays 0 until engine 0's last beat is accepted, then grant=3'b010 after one IDLE cycle.
- Abort by drop: engine 2 granted, drops req after 3 beats with no last -> 3 writes; abort=1 for one cycle; next requester is searched starting at engine 0.
- Timeout: MAX_BURST=8, engine 1 streams with no last -> exactly 8 vga_write pulses, then abort pulses, grant drops, and engine 1 is regranted only after one IDLE cycle, provided no other engine is requesting.
- Reset mid-burst: reset asserted during beat 3 of a 6-beat burst -> next cycle grant=0, vga_write=0, busy=0, owner=0. After reset releases with req[0] and req[2] both high, engine 0 is granted first.
